// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALUOP codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMREAD = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECR   = 4'd6,
    ST_EXECI   = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BEQ     = 4'd9,
    ST_JAL     = 4'd10,
    ST_HALT    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over the shared datapath and stalls on the MEMREADY handshake.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP,
  input  logic       ZERO,
  input  logic       MEMREADY,
  output logic       PCWRITE,
  output logic       ADRSRC,
  output logic       MEMWRITE,
  output logic       IRWRITE,
  output logic       REGWRITE,
  output logic [1:0] RESULTSRC,
  output logic [1:0] ALUSRCA,
  output logic [1:0] ALUSRCB,
  output logic [1:0] ALUOP,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  // Handshake: MEMREADY=1 in a cycle means the memory finished the access
  // presented that cycle; a waiting state advances only on such a cycle.
  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_rdy;
  logic   pc_update, branch;

  assign mem_rdy = MEM_WAIT_EN ? MEMREADY : 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = ST_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:   state_d = mem_rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECR;
          OP_ITYPE:     state_d = ST_EXECI;
          OP_BEQ:       state_d = ST_BEQ;
          OP_JAL:       state_d = ST_JAL;
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR:  state_d = OP[5] ? ST_MEMWR : ST_MEMREAD;
      ST_MEMREAD: state_d = mem_rdy ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_MEMWR:   state_d = mem_rdy ? ST_FETCH : ST_MEMWR;
      ST_EXECR, ST_EXECI, ST_JAL: state_d = ST_ALUWB;
      ST_ALUWB, ST_BEQ:           state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ADRSRC    = 1'b0;
    MEMWRITE  = 1'b0;
    IRWRITE   = 1'b0;
    REGWRITE  = 1'b0;
    RESULTSRC = RES_ALUOUT;
    ALUSRCA   = SRCA_PC;
    ALUSRCB   = SRCB_RD2;
    ALUOP     = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        ALUSRCA   = SRCA_PC;
        ALUSRCB   = SRCB_FOUR;
        RESULTSRC = RES_ALURESULT;
        IRWRITE   = mem_rdy;
        pc_update = mem_rdy;
      end
      ST_DECODE: begin
        ALUSRCA = SRCA_OLDPC;
        ALUSRCB = SRCB_IMM;
      end
      ST_MEMADR: begin
        ALUSRCA = SRCA_RD1;
        ALUSRCB = SRCB_IMM;
      end
      ST_MEMREAD: ADRSRC = 1'b1;
      ST_MEMWB: begin
        RESULTSRC = RES_DATA;
        REGWRITE  = 1'b1;
      end
      ST_MEMWR: begin
        ADRSRC   = 1'b1;
        MEMWRITE = 1'b1;
      end
      ST_EXECR: begin
        ALUSRCA = SRCA_RD1;
        ALUOP   = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        ALUSRCA = SRCA_RD1;
        ALUSRCB = SRCB_IMM;
        ALUOP   = ALUOP_FUNCT;
      end
      ST_ALUWB: REGWRITE = 1'b1;
      ST_BEQ: begin
        ALUSRCA = SRCA_RD1;
        ALUOP   = ALUOP_SUB;
        branch  = 1'b1;
      end
      ST_JAL: begin
        ALUSRCA   = SRCA_OLDPC;
        ALUSRCB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    PCWRITE = pc_update | (branch & ZERO);
    // Reset overrides every strobe and select so nothing leaks into the datapath.
    if (RST) begin
      PCWRITE   = 1'b0;
      ADRSRC    = 1'b0;
      MEMWRITE  = 1'b0;
      IRWRITE   = 1'b0;
      REGWRITE  = 1'b0;
      RESULTSRC = 2'b00;
      ALUSRCA   = 2'b00;
      ALUSRCB   = 2'b00;
      ALUOP     = 2'b00;
    end
  end

  assign ILLEGAL = illegal_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized instruction-level bench for multicycle_main_fsm with an expected-output
// queue filled by the driver and drained by a negedge monitor.
module tb_multicycle_main_fsm;
  import riscv_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, ZERO, MEMREADY;
  logic [6:0] OP;
  logic       PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE, ILLEGAL;
  logic [1:0] RESULTSRC, ALUSRCA, ALUSRCB, ALUOP;
  logic [3:0] STATE;

  multicycle_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .OP(OP), .ZERO(ZERO), .MEMREADY(MEMREADY),
    .PCWRITE(PCWRITE), .ADRSRC(ADRSRC), .MEMWRITE(MEMWRITE), .IRWRITE(IRWRITE),
    .REGWRITE(REGWRITE), .RESULTSRC(RESULTSRC), .ALUSRCA(ALUSRCA), .ALUSRCB(ALUSRCB),
    .ALUOP(ALUOP), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop;
  } outs_t;

  outs_t       tbl [16];
  logic [17:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pcw_cnt = 0;
  logic        cur_ill = 1'b0;

  function automatic outs_t mk(logic pcw, logic adr, logic mw, logic irw, logic rw,
                               int rs, int sa, int sb, int aop);
    outs_t o;
    o.pcw = pcw; o.adr = adr; o.mw = mw; o.irw = irw; o.rw = rw;
    o.rs = rs[1:0]; o.sa = sa[1:0]; o.sb = sb[1:0]; o.aop = aop[1:0];
    return o;
  endfunction

  function automatic logic [17:0] expect_vec(state_e st, logic rst, logic mr, logic z, logic ill);
    outs_t o;
    o = rst ? '0 : tbl[int'(st)];
    if (!rst && st == ST_FETCH) begin
      o.irw = mr;
      o.pcw = mr;
    end
    if (!rst && st == ST_BEQ) o.pcw = z;
    return {st, o, ill};
  endfunction

  function automatic logic is_legal(logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  function automatic logic [6:0] op_for(state_e st, logic [6:0] op);
    if (st == ST_DECODE || st == ST_MEMADR) return op;
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic step(state_e st, logic mr, logic z, logic [6:0] op);
    RST = 1'b0; MEMREADY = mr; ZERO = z; OP = op;
    exp_q.push_back(expect_vec(st, 1'b0, mr, z, cur_ill));
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(int n, state_e from);
    for (int i = 0; i < n; i++) begin
      RST = 1'b1;
      MEMREADY = 1'($urandom_range(0, 1));
      ZERO = 1'($urandom_range(0, 1));
      OP = 7'($urandom_range(0, 127));
      exp_q.push_back(expect_vec(i == 0 ? from : ST_FETCH, 1'b1, MEMREADY, ZERO,
                                 i == 0 ? cur_ill : 1'b0));
      @(posedge CLK); #1;
    end
    cur_ill = 1'b0;
  endtask

  // Instruction-level reference: the opcode picks a path of steps; waiting steps
  // repeat for the requested number of stall cycles before MEMREADY is granted.
  task automatic run_instr(logic [6:0] op, logic z, int fstall, int mstall);
    state_e path[$];
    state_e st;
    int     n;
    path.push_back(ST_FETCH);
    path.push_back(ST_DECODE);
    case (op)
      7'b0000011: begin path.push_back(ST_MEMADR); path.push_back(ST_MEMREAD); path.push_back(ST_MEMWB); end
      7'b0100011: begin path.push_back(ST_MEMADR); path.push_back(ST_MEMWR); end
      7'b0110011: begin path.push_back(ST_EXECR); path.push_back(ST_ALUWB); end
      7'b0010011: begin path.push_back(ST_EXECI); path.push_back(ST_ALUWB); end
      7'b1100011: path.push_back(ST_BEQ);
      7'b1101111: begin path.push_back(ST_JAL); path.push_back(ST_ALUWB); end
      default:    path.push_back(ST_HALT);
    endcase
    for (int i = 0; i < path.size(); i++) begin
      st = path[i];
      if (st == ST_FETCH || st == ST_MEMREAD || st == ST_MEMWR) begin
        n = (st == ST_FETCH) ? fstall : mstall;
        for (int k = 0; k < n; k++) step(st, 1'b0, 1'($urandom_range(0, 1)), op_for(st, op));
        step(st, 1'b1, 1'($urandom_range(0, 1)), op_for(st, op));
      end else if (st == ST_HALT) begin
        cur_ill = 1'b1;
        for (int k = 0; k <= mstall; k++)
          step(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op_for(st, op));
      end else begin
        step(st, 1'($urandom_range(0, 1)),
             (st == ST_BEQ) ? z : 1'($urandom_range(0, 1)), op_for(st, op));
      end
    end
  endtask

  task automatic monitor();
    logic [17:0] exp_v, act_v;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {STATE, PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE,
                 RESULTSRC, ALUSRCA, ALUSRCB, ALUOP, ILLEGAL};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t: got state=%0d outs=%b, expected state=%0d outs=%b",
                   $time, act_v[17:14], act_v[13:0], exp_v[17:14], exp_v[13:0]);
        end
        if (PCWRITE === 1'b1) pcw_cnt++;
      end
    end
  endtask

  task automatic watchdog();
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    int         pcw_before;
    logic [6:0] op;
    logic [6:0] legal_ops [6];

    tbl[int'(ST_FETCH)]   = mk(0, 0, 0, 0, 0, 2, 0, 2, 0);
    tbl[int'(ST_DECODE)]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[int'(ST_MEMADR)]  = mk(0, 0, 0, 0, 0, 0, 2, 1, 0);
    tbl[int'(ST_MEMREAD)] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[int'(ST_MEMWB)]   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[int'(ST_MEMWR)]   = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[int'(ST_EXECR)]   = mk(0, 0, 0, 0, 0, 0, 2, 0, 2);
    tbl[int'(ST_EXECI)]   = mk(0, 0, 0, 0, 0, 0, 2, 1, 2);
    tbl[int'(ST_ALUWB)]   = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[int'(ST_BEQ)]     = mk(0, 0, 0, 0, 0, 0, 2, 0, 1);
    tbl[int'(ST_JAL)]     = mk(1, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[int'(ST_HALT)]    = '0;
    for (int i = 12; i < 16; i++) tbl[i] = '0;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    RST = 1'b1; MEMREADY = 1'b0; ZERO = 1'b0; OP = 7'd0;
    fork
      monitor();
      watchdog();
    join_none
    repeat (2) @(posedge CLK);
    #1;
    do_reset(2, ST_FETCH);

    // Reset held three cycles while a load is stalled in MEMREAD.
    step(ST_FETCH, 1'b1, 1'b0, 7'd0);
    step(ST_DECODE, 1'b1, 1'b0, 7'b0000011);
    step(ST_MEMADR, 1'b1, 1'b0, 7'b0000011);
    step(ST_MEMREAD, 1'b0, 1'b0, 7'b0000011);
    step(ST_MEMREAD, 1'b0, 1'b0, 7'b0000011);
    do_reset(3, ST_MEMREAD);

    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 0, 2);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);

    // Four stalled fetch cycles must produce exactly one PC write for an R-type.
    pcw_before = pcw_cnt;
    run_instr(7'b0110011, 1'b0, 4, 0);
    n_tests++;
    if (pcw_cnt - pcw_before != 1) begin
      n_fail++;
      $display("FAIL pc_increment_once: got %0d PC writes, expected 1", pcw_cnt - pcw_before);
    end

    run_instr(7'b1111111, 1'b0, 0, 4);
    do_reset(2, ST_HALT);

    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));

    for (int i = 0; i < 4; i++) begin
      op = 7'($urandom_range(0, 127));
      while (is_legal(op)) op = 7'($urandom_range(0, 127));
      run_instr(op, 1'b0, $urandom_range(0, 2), $urandom_range(1, 3));
      do_reset($urandom_range(1, 3), ST_HALT);
      run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 0, 0);
    end

    @(negedge CLK);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
